cdc_event_sync: RTL and testbench



---
 rtl/cdc_pkg.sv | 28 ++
 rtl/cdc_sync_chain.sv | 43 ++++
 rtl/cdc_event_sync.sv | 138 +++++++++++++
 tb/tb_cdc_event_sync.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
// Shared constants and helpers for the CDC primitive family.
//   SYNC_FF_MIN / SYNC_FF_MAX : legal synchronizer depth range
//   CHANNELS_MIN / CHANNELS_MAX : legal channel count range
//   chan_mode_e               : per-channel decode mode (level / toggle)
//   edge_event()              : event decode for one channel
// ---------------------------------------------------------------------------
package cdc_pkg;

    localparam int SYNC_FF_MIN  = 2;
    localparam int SYNC_FF_MAX  = 10;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 32;

    typedef enum logic {
        MODE_LEVEL  = 1'b0,
        MODE_TOGGLE = 1'b1
    } chan_mode_e;

    // Level channels report rising edges only; toggle channels report any change.
    function automatic logic edge_event(input chan_mode_e mode,
                                        input logic       cur,
                                        input logic       prev);
        return (mode == MODE_TOGGLE) ? (cur ^ prev) : (cur & ~prev);
    endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// ---------------------------------------------------------------------------
// cdc_sync_chain
// WIDTH-bit wide, DEPTH-deep flop chain for bringing asynchronous signals
// into clk. Every stage carries ASYNC_REG so placement keeps the flops
// together and timing tools treat them as a synchronizer.
// Ports:
//   clk   : destination clock
//   reset : synchronous, active-high; clears every stage
//   d_i   : asynchronous input bits
//   q_o   : synchronized output (last stage)
// ---------------------------------------------------------------------------
module cdc_sync_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage_q;
        logic [WIDTH-1:0] stage_d;

        if (gi == 0) begin : g_first
            assign stage_d = d_i;
        end else begin : g_next
            assign stage_d = g_stage[gi-1].stage_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign q_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/cdc_event_sync.sv
// ---------------------------------------------------------------------------
// cdc_event_sync
// Synchronizes CHANNELS asynchronous inputs, turns level edges or toggles
// into one-cycle pulses, and presents them as a valid/ready event word.
// Events arriving while the consumer stalls are OR-merged into an
// accumulator; a sticky per-channel overflow flag marks merged (lost) events.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   async_in     : asynchronous inputs
//   sync_out     : synchronized level of async_in
//   pulse        : registered one-cycle event strobe per channel
//   event_data   : captured event bitmap (valid with event_valid)
//   event_valid  : event_data holds at least one event
//   event_ready  : consumer accepts event_data this cycle
//   overflow     : sticky per-channel event-loss flag
//   clr_overflow : clears overflow (a simultaneous new loss still sets)
// ---------------------------------------------------------------------------
module cdc_event_sync
    import cdc_pkg::*;
#(
    parameter int                  CHANNELS    = 4,
    parameter int                  SYNC_FF     = 4,
    parameter logic [CHANNELS-1:0] TOGGLE_MODE = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] async_in,
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] event_data,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [CHANNELS-1:0] overflow,
    input  logic                clr_overflow
);

    if (SYNC_FF < SYNC_FF_MIN || SYNC_FF > SYNC_FF_MAX) begin : g_bad_sync_ff
        $error("cdc_event_sync: SYNC_FF out of range");
    end
    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
        $error("cdc_event_sync: CHANNELS out of range");
    end

    localparam int                WARM_W    = $clog2(SYNC_FF + 2);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_FF + 1);

    logic [CHANNELS-1:0] sync_w;
    logic [CHANNELS-1:0] edge_w;
    logic [CHANNELS-1:0] merged_w;
    logic [CHANNELS-1:0] lost_w;

    logic [WARM_W-1:0]   warm_q,  warm_d;
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] data_q,  data_d;
    logic                valid_q, valid_d;
    logic [CHANNELS-1:0] acc_q,   acc_d;
    logic [CHANNELS-1:0] ovf_q,   ovf_d;

    cdc_sync_chain #(
        .WIDTH (CHANNELS),
        .DEPTH (SYNC_FF)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (async_in),
        .q_o   (sync_w)
    );

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_edge
        assign edge_w[gi] = edge_event(chan_mode_e'(TOGGLE_MODE[gi]), sync_w[gi], prev_q[gi]);
    end

    assign merged_w = acc_q | pulse_q;

    always_comb begin
        // Warm-up: pulses are suppressed until the counter reaches zero, while
        // prev_q keeps tracking sync_out so a level already present at reset
        // never looks like an edge.
        warm_d  = (warm_q != '0) ? (warm_q - WARM_W'(1)) : warm_q;
        pulse_d = (warm_q == '0) ? edge_w : '0;

        data_d  = data_q;
        valid_d = valid_q;
        acc_d   = acc_q;
        lost_w  = '0;

        if (!valid_q) begin
            if (pulse_q != '0) begin
                data_d  = pulse_q;
                valid_d = 1'b1;
            end
        end else if (event_ready) begin
            // Accepted: refill straight from the accumulator plus this cycle's
            // events so a continuous stream has no bubble.
            acc_d = '0;
            if (merged_w != '0) begin
                data_d = merged_w;
            end else begin
                valid_d = 1'b0;
                data_d  = '0;
            end
        end else begin
            // Stalled: event_data is frozen, new events merge into acc.
            acc_d  = merged_w;
            lost_w = pulse_q & acc_q;
        end

        ovf_d = (clr_overflow ? '0 : ovf_q) | lost_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q  <= WARM_INIT;
            prev_q  <= '0;
            pulse_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= '0;
        end else begin
            warm_q  <= warm_d;
            prev_q  <= sync_w;
            pulse_q <= pulse_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sync_out    = sync_w;
    assign pulse       = pulse_q;
    assign event_data  = data_q;
    assign event_valid = valid_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_cdc_event_sync.sv
// ---------------------------------------------------------------------------
// tb_cdc_event_sync
// Bench for cdc_event_sync with CHANNELS=4, SYNC_FF=4, TOGGLE_MODE=4'b0100.
// Expected event words are queued as stimulus is driven; a negedge monitor
// pops and compares each accepted word.
// ---------------------------------------------------------------------------
module tb_cdc_event_sync;

    localparam int              CH  = 4;
    localparam int              SFF = 4;
    localparam logic [CH-1:0]   TM  = 4'b0100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] async_in = '0;
    logic [CH-1:0] sync_out;
    logic [CH-1:0] pulse;
    logic [CH-1:0] event_data;
    logic          event_valid;
    logic          event_ready = 1'b0;
    logic [CH-1:0] overflow;
    logic          clr_overflow = 1'b0;

    logic [CH-1:0] exp_q[$];
    logic [CH-1:0] exp_w;
    int            total = 0;
    int            bad = 0;
    int            valid_cycles = 0;
    int            pulse_cnt[CH];

    cdc_event_sync #(
        .CHANNELS    (CH),
        .SYNC_FF     (SFF),
        .TOGGLE_MODE (TM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .async_in     (async_in),
        .sync_out     (sync_out),
        .pulse        (pulse),
        .event_data   (event_data),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // Monitor: counts pulses/valid cycles and checks every handshake word.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                if (pulse[i]) pulse_cnt[i]++;
            end
            if (event_valid) valid_cycles++;
            if (event_valid && event_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL word_unexpected got=%b want=none", event_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (event_data !== exp_w) begin
                        bad++;
                        $display("FAIL word_data got=%b want=%b", event_data, exp_w);
                    end else begin
                        $display("word accepted data=%b t=%0t", event_data, $time);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < CH; i++) pulse_cnt[i] = 0;
        valid_cycles = 0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        async_in = 4'b0001;
        step(3);
        total++;
        if (event_valid !== 1'b0 || event_data !== 4'b0000 || overflow !== 4'b0000 ||
            pulse !== 4'b0000 || sync_out !== 4'b0000) begin
            bad++;
            $display("FAIL reset_values got=v%b d%b o%b p%b s%b want=all zero",
                     event_valid, event_data, overflow, pulse, sync_out);
        end
        reset = 1'b0;
        clear_counts();
        step(3);
        total++;
        if (sync_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_sync_early got=%b want=0", sync_out[0]);
        end
        step(1);
        total++;
        if (sync_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_sync_latency got=%b want=1", sync_out[0]);
        end
        step(20);
        total++;
        if (pulse_cnt[0] != 0 || valid_cycles != 0) begin
            bad++;
            $display("FAIL reset_no_event got=pulses %0d valid %0d want=0 0", pulse_cnt[0], valid_cycles);
        end
        async_in[0] = 1'b0;
        step(8);
        total++;
        if (pulse_cnt[0] != 0) begin
            bad++;
            $display("FAIL reset_fall_event got=%0d want=0", pulse_cnt[0]);
        end
        $display("test_reset done");
    endtask

    task automatic test_level_edge();
        clear_counts();
        event_ready = 1'b1;
        async_in[1] = 1'b1;
        exp_q.push_back(4'b0010);
        step(4);
        total++;
        if (pulse !== 4'b0000) begin
            bad++;
            $display("FAIL level_pulse_early got=%b want=0000", pulse);
        end
        step(1);
        total++;
        if (pulse !== 4'b0010) begin
            bad++;
            $display("FAIL level_pulse got=%b want=0010", pulse);
        end
        step(1);
        total++;
        if (event_valid !== 1'b1 || event_data !== 4'b0010 || pulse !== 4'b0000) begin
            bad++;
            $display("FAIL level_valid got=v%b d%b p%b want=v1 d0010 p0000", event_valid, event_data, pulse);
        end
        step(1);
        total++;
        if (event_valid !== 1'b0) begin
            bad++;
            $display("FAIL level_valid_drop got=%b want=0", event_valid);
        end
        async_in[1] = 1'b0;
        step(10);
        total++;
        if (pulse_cnt[1] != 1 || valid_cycles != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL level_single got=pulses %0d valid %0d pend %0d want=1 1 0",
                     pulse_cnt[1], valid_cycles, exp_q.size());
        end
        $display("test_level_edge done");
    endtask

    task automatic test_toggle();
        clear_counts();
        event_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            async_in[2] = ~async_in[2];
            exp_q.push_back(4'b0100);
            step(4);
        end
        step(10);
        total++;
        if (pulse_cnt[2] != 3 || valid_cycles != 3 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL toggle_words got=pulses %0d valid %0d pend %0d want=3 3 0",
                     pulse_cnt[2], valid_cycles, exp_q.size());
        end
        $display("test_toggle done");
    endtask

    task automatic test_stall_merge();
        clear_counts();
        event_ready = 1'b0;
        async_in[0] = 1'b1;
        exp_q.push_back(4'b0001);
        step(3);
        async_in[3] = 1'b1;
        exp_q.push_back(4'b1000);
        step(5);
        total++;
        if (event_valid !== 1'b1 || event_data !== 4'b0001) begin
            bad++;
            $display("FAIL stall_first got=v%b d%b want=v1 d0001", event_valid, event_data);
        end
        step(6);
        total++;
        if (event_valid !== 1'b1 || event_data !== 4'b0001) begin
            bad++;
            $display("FAIL stall_hold got=v%b d%b want=v1 d0001", event_valid, event_data);
        end
        event_ready = 1'b1;
        step(5);
        event_ready = 1'b0;
        total++;
        if (exp_q.size() != 0 || overflow !== 4'b0000 || event_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_drain got=pend %0d ovf %b v%b want=0 0000 0",
                     exp_q.size(), overflow, event_valid);
        end
        async_in[0] = 1'b0;
        async_in[3] = 1'b0;
        step(8);
        $display("test_stall_merge done");
    endtask

    task automatic test_overflow();
        clear_counts();
        event_ready = 1'b0;
        async_in[0] = 1'b1;
        exp_q.push_back(4'b0001);
        step(3);
        async_in[0] = 1'b0;
        step(3);
        async_in[0] = 1'b1;
        exp_q.push_back(4'b0001);
        step(3);
        total++;
        if (overflow !== 4'b0000) begin
            bad++;
            $display("FAIL ovf_early got=%b want=0000", overflow);
        end
        async_in[0] = 1'b0;
        step(3);
        async_in[0] = 1'b1;
        step(10);
        total++;
        if (overflow !== 4'b0001) begin
            bad++;
            $display("FAIL ovf_set got=%b want=0001", overflow);
        end
        step(5);
        total++;
        if (overflow !== 4'b0001) begin
            bad++;
            $display("FAIL ovf_sticky got=%b want=0001", overflow);
        end
        // Fourth event: clear is asserted in exactly the cycle the loss is recorded.
        async_in[0] = 1'b0;
        step(3);
        async_in[0] = 1'b1;
        step(5);
        total++;
        if (pulse !== 4'b0001) begin
            bad++;
            $display("FAIL ovf_pulse_align got=%b want=0001", pulse);
        end
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        total++;
        if (overflow !== 4'b0001) begin
            bad++;
            $display("FAIL ovf_set_wins got=%b want=0001", overflow);
        end
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        total++;
        if (overflow !== 4'b0000) begin
            bad++;
            $display("FAIL ovf_clear got=%b want=0000", overflow);
        end
        event_ready = 1'b1;
        step(5);
        event_ready = 1'b0;
        total++;
        if (exp_q.size() != 0 || overflow !== 4'b0000) begin
            bad++;
            $display("FAIL ovf_drain got=pend %0d ovf %b want=0 0000", exp_q.size(), overflow);
        end
        async_in[0] = 1'b0;
        step(8);
        $display("test_overflow done");
    endtask

    task automatic test_reset_midop();
        event_ready = 1'b0;
        async_in[1] = 1'b1;
        step(3);
        async_in[1] = 1'b0;
        step(3);
        async_in[1] = 1'b1;
        step(3);
        async_in[1] = 1'b0;
        step(3);
        async_in[1] = 1'b1;
        step(8);
        total++;
        if (event_valid !== 1'b1 || overflow !== 4'b0010) begin
            bad++;
            $display("FAIL midop_pre got=v%b ovf %b want=v1 ovf 0010", event_valid, overflow);
        end
        reset = 1'b1;
        step(1);
        total++;
        if (event_valid !== 1'b0 || event_data !== 4'b0000 || overflow !== 4'b0000) begin
            bad++;
            $display("FAIL midop_reset got=v%b d%b ovf %b want=v0 d0000 ovf 0000",
                     event_valid, event_data, overflow);
        end
        reset = 1'b0;
        clear_counts();
        event_ready = 1'b1;
        step(SFF + 1);
        total++;
        if (pulse_cnt[1] != 0 || valid_cycles != 0) begin
            bad++;
            $display("FAIL midop_warmup got=pulses %0d valid %0d want=0 0", pulse_cnt[1], valid_cycles);
        end
        step(15);
        total++;
        if (pulse_cnt[1] != 0 || valid_cycles != 0) begin
            bad++;
            $display("FAIL midop_quiet got=pulses %0d valid %0d want=0 0", pulse_cnt[1], valid_cycles);
        end
        async_in[1] = 1'b0;
        step(3);
        async_in[1] = 1'b1;
        exp_q.push_back(4'b0010);
        step(10);
        total++;
        if (pulse_cnt[1] != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL midop_recover got=pulses %0d pend %0d want=1 0", pulse_cnt[1], exp_q.size());
        end
        $display("test_reset_midop done");
    endtask

    task automatic test_back_to_back();
        clear_counts();
        event_ready = 1'b1;
        async_in[0] = 1'b1;
        exp_q.push_back(4'b0001);
        step(1);
        async_in[3] = 1'b1;
        exp_q.push_back(4'b1000);
        step(1);
        async_in[2] = ~async_in[2];
        exp_q.push_back(4'b0100);
        step(12);
        total++;
        if (valid_cycles != 3 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_stream got=valid %0d pend %0d want=3 0", valid_cycles, exp_q.size());
        end
        total++;
        if (pulse_cnt[0] != 1 || pulse_cnt[2] != 1 || pulse_cnt[3] != 1 || pulse_cnt[1] != 0) begin
            bad++;
            $display("FAIL b2b_pulses got=%0d %0d %0d %0d want=1 0 1 1",
                     pulse_cnt[0], pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        for (int i = 0; i < CH; i++) pulse_cnt[i] = 0;
        test_reset();
        test_level_edge();
        test_toggle();
        test_stall_merge();
        test_overflow();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
